// File: rtl/cc_frame_loader.sv
// cc_frame_loader
// Serial front-end and result collector for the combinational code calculator.
// Takes five 4-bit operand beats plus an opcode over a valid/ready stream,
// presents them as registered values to the calculator, waits CALC_LAT settle
// cycles, captures the signed 10-bit result and returns it on a valid/ready
// result stream.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand beat handshake, in_data nibble, in_opt opcode
//                     (in_opt is sampled on the first beat only)
//   cc_opt, cc_in0..4 registered opcode/operands driven to the calculator
//   cc_out            signed result from the calculator
//   out_valid/out_ready/out_data  result handshake and captured result
//   busy              high whenever the loader is not idle
//   frame_cnt         number of delivered results, wraps modulo 2^CNT_W
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// LOAD  | collecting beats 1..4
// CALC  | calculator settling, wait counter running down
// HOLD  | result presented, waiting for out_ready
module cc_frame_loader #(
  parameter int CALC_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_data,
  input  logic [2:0]        in_opt,
  output logic [2:0]        cc_opt,
  output logic [3:0]        cc_in0,
  output logic [3:0]        cc_in1,
  output logic [3:0]        cc_in2,
  output logic [3:0]        cc_in3,
  output logic [3:0]        cc_in4,
  input  logic signed [9:0] cc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [9:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, HOLD} state_t;

  localparam logic [3:0] LAT = 4'(CALC_LAT);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] beat_cnt;
  logic [3:0] wait_cnt;
  logic       accept;

  assign accept = in_valid & in_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: if (accept && beat_cnt == 3'd4) state_nxt = CALC;
      CALC: if (wait_cnt == 4'd0) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs; out_valid is high exactly while the result is held
  always_comb begin
    in_ready  = (state == IDLE) || (state == LOAD);
    busy      = (state != IDLE);
    out_valid = (state == HOLD);
  end

  // datapath: operand slots, counters and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      cc_opt    <= '0;
      cc_in0    <= '0;
      cc_in1    <= '0;
      cc_in2    <= '0;
      cc_in3    <= '0;
      cc_in4    <= '0;
      out_data  <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cc_in0   <= in_data;
            cc_opt   <= in_opt;
            beat_cnt <= 3'd1;
          end
        end
        LOAD: begin
          if (accept) begin
            case (beat_cnt)
              3'd1:    cc_in1 <= in_data;
              3'd2:    cc_in2 <= in_data;
              3'd3:    cc_in3 <= in_data;
              default: cc_in4 <= in_data;
            endcase
            beat_cnt <= beat_cnt + 3'd1;
            if (beat_cnt == 3'd4) wait_cnt <= LAT;
          end
        end
        CALC: begin
          if (wait_cnt == 4'd0) out_data <= cc_out;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        HOLD: begin
          if (out_ready) frame_cnt <= frame_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_frame_loader.sv
module tb_cc_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] in_data;
  logic [2:0] in_opt;
  logic       stub_neg1;

  logic       in_valid_v  [3];
  logic       in_ready_v  [3];
  logic       out_valid_v [3];
  logic       out_ready_v [3];
  logic       busy_v      [3];
  logic [2:0] cc_opt_v    [3];
  logic [3:0] cc_in_v     [3][5];
  logic [9:0] cc_out_v    [3];
  logic [9:0] out_data_v  [3];
  logic [7:0] frame_cnt_v [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] sb[$];
  int exp_cnt[3];
  int lat_of[3] = '{1, 0, 15};
  logic [3:0] dv[5];

  cc_frame_loader #(.CALC_LAT(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_opt(in_opt), .cc_opt(cc_opt_v[0]),
    .cc_in0(cc_in_v[0][0]), .cc_in1(cc_in_v[0][1]), .cc_in2(cc_in_v[0][2]),
    .cc_in3(cc_in_v[0][3]), .cc_in4(cc_in_v[0][4]), .cc_out(cc_out_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data_v[0]),
    .busy(busy_v[0]), .frame_cnt(frame_cnt_v[0]));

  cc_frame_loader #(.CALC_LAT(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_opt(in_opt), .cc_opt(cc_opt_v[1]),
    .cc_in0(cc_in_v[1][0]), .cc_in1(cc_in_v[1][1]), .cc_in2(cc_in_v[1][2]),
    .cc_in3(cc_in_v[1][3]), .cc_in4(cc_in_v[1][4]), .cc_out(cc_out_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data_v[1]),
    .busy(busy_v[1]), .frame_cnt(frame_cnt_v[1]));

  cc_frame_loader #(.CALC_LAT(15), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_opt(in_opt), .cc_opt(cc_opt_v[2]),
    .cc_in0(cc_in_v[2][0]), .cc_in1(cc_in_v[2][1]), .cc_in2(cc_in_v[2][2]),
    .cc_in3(cc_in_v[2][3]), .cc_in4(cc_in_v[2][4]), .cc_out(cc_out_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_data(out_data_v[2]),
    .busy(busy_v[2]), .frame_cnt(frame_cnt_v[2]));

  // Stand-in calculator: opt 000 -> a+e, 100 -> c+d, 001 -> a-b-c-d-e, else a*b-e.
  function automatic logic [9:0] calc_ref(input logic [2:0] opt,
      input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
      input logic [3:0] d, input logic [3:0] e);
    int r;
    case (opt)
      3'b000:  r = int'(a) + int'(e);
      3'b100:  r = int'(c) + int'(d);
      3'b001:  r = int'(a) - int'(b) - int'(c) - int'(d) - int'(e);
      default: r = int'(a) * int'(b) - int'(e);
    endcase
    return 10'(r);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_calc
    always_comb
      cc_out_v[g] = stub_neg1 ? 10'h3FF
                  : calc_ref(cc_opt_v[g], cc_in_v[g][0], cc_in_v[g][1],
                             cc_in_v[g][2], cc_in_v[g][3], cc_in_v[g][4]);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    sb.delete();
  endtask

  task automatic check_zero(input int i, input string name);
    n_checks++;
    if ({cc_opt_v[i], cc_in_v[i][0], cc_in_v[i][1], cc_in_v[i][2], cc_in_v[i][3],
         cc_in_v[i][4], out_data_v[i], out_valid_v[i], busy_v[i], frame_cnt_v[i]} !== '0) begin
      n_fail++;
      $display("FAIL %s[%0d]: outputs not cleared opt=%h in=%h%h%h%h%h data=%h valid=%b busy=%b cnt=%0d, required all 0",
               name, i, cc_opt_v[i], cc_in_v[i][0], cc_in_v[i][1], cc_in_v[i][2], cc_in_v[i][3],
               cc_in_v[i][4], out_data_v[i], out_valid_v[i], busy_v[i], frame_cnt_v[i]);
    end
    n_checks++;
    if (in_ready_v[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready[%0d]: got %b required 1", name, i, in_ready_v[i]);
    end
  endtask

  // Drives nbeats beats from dv; a full frame also measures result latency.
  task automatic send_frame(input int i, input logic [2:0] opt, input int nbeats,
                            input int gap, input logic toggle);
    int cyc;
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      in_valid_v[i] = 1'b1;
      in_data = dv[k];
      in_opt = (k == 0) ? opt : (toggle ? ~opt : opt);
      n_checks++;
      if (in_ready_v[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL beat_ready[%0d] beat %0d: got %b required 1", i, k, in_ready_v[i]);
      end
      @(posedge clk);
      if (k < nbeats - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid_v[i] = 1'b0;
          in_data = 4'hF;
          @(posedge clk);
        end
      end
    end
    if (nbeats < 5) begin
      @(negedge clk);
      in_valid_v[i] = 1'b0;
      return;
    end
    sb.push_back(stub_neg1 ? 10'h3FF : calc_ref(opt, dv[0], dv[1], dv[2], dv[3], dv[4]));
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      in_valid_v[i] = 1'b0;
      if (out_valid_v[i] === 1'b1) break;
      @(posedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != lat_of[i] + 1) begin
      n_fail++;
      $display("FAIL latency[%0d]: out_valid after %0d cycles, required %0d", i, cyc, lat_of[i] + 1);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cc_in_v[i][k] !== dv[k]) begin
        n_fail++;
        $display("FAIL cc_in%0d[%0d]: got %h required %h", k, i, cc_in_v[i][k], dv[k]);
      end
    end
    n_checks++;
    if (cc_opt_v[i] !== opt) begin
      n_fail++;
      $display("FAIL cc_opt[%0d]: got %b required %b", i, cc_opt_v[i], opt);
    end
  endtask

  // Entered at the negedge where out_valid was first seen.
  task automatic get_result(input int i, input int hold);
    logic [9:0] exp_d;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard[%0d]: empty, required a pending result", i);
      return;
    end
    exp_d = sb[0];
    for (int h = 0; h < hold; h++) begin
      n_checks++;
      if (out_valid_v[i] !== 1'b1 || out_data_v[i] !== exp_d || in_ready_v[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d] cycle %0d: valid=%b data=%h ready=%b, required valid=1 data=%h ready=0",
                 i, h, out_valid_v[i], out_data_v[i], in_ready_v[i], exp_d);
      end
      @(negedge clk);
    end
    out_ready_v[i] = 1'b1;
    exp_d = sb.pop_front();
    n_checks++;
    if (out_valid_v[i] !== 1'b1 || out_data_v[i] !== exp_d) begin
      n_fail++;
      $display("FAIL result[%0d]: valid=%b data=%h, required valid=1 data=%h",
               i, out_valid_v[i], out_data_v[i], exp_d);
    end
    @(negedge clk);
    out_ready_v[i] = 1'b0;
    exp_cnt[i] = (exp_cnt[i] + 1) % 256;
    n_checks++;
    if (out_valid_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || frame_cnt_v[i] !== 8'(exp_cnt[i])) begin
      n_fail++;
      $display("FAIL after_hs[%0d]: valid=%b busy=%b cnt=%0d, required valid=0 busy=0 cnt=%0d",
               i, out_valid_v[i], busy_v[i], frame_cnt_v[i], exp_cnt[i]);
    end
  endtask

  task automatic set_dv(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] e);
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d; dv[4] = e;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
  endtask

  task automatic test_basic();
    set_dv(1, 2, 3, 4, 5);
    send_frame(0, 3'b000, 5, 0, 1'b0);
    get_result(0, 0);
  endtask

  task automatic test_opcode();
    set_dv(1, 2, 3, 4, 5);
    send_frame(0, 3'b100, 5, 0, 1'b1);
    get_result(0, 0);
  endtask

  task automatic test_throttle();
    set_dv(9, 3, 1, 2, 0);
    send_frame(0, 3'b001, 5, 3, 1'b0);
    get_result(0, 10);
  endtask

  task automatic test_latency();
    set_dv(7, 6, 5, 4, 3);
    send_frame(1, 3'b010, 5, 0, 1'b0);
    get_result(1, 0);
    set_dv(15, 15, 0, 1, 14);
    send_frame(2, 3'b001, 5, 1, 1'b1);
    get_result(2, 2);
  endtask

  task automatic test_reset_midop();
    set_dv(2, 4, 6, 8, 10);
    send_frame(0, 3'b011, 3, 0, 1'b0);
    do_reset();
    check_zero(0, "rst_load");
    send_frame(0, 3'b011, 5, 0, 1'b0);
    do_reset();
    check_zero(0, "rst_hold");
    set_dv(5, 0, 3, 3, 9);
    send_frame(0, 3'b000, 5, 0, 1'b0);
    get_result(0, 1);
  endtask

  task automatic test_back_to_back();
    // out_ready held high outside HOLD must neither count nor disturb the frame.
    out_ready_v[0] = 1'b1;
    set_dv(3, 1, 4, 1, 5);
    send_frame(0, 3'b110, 5, 0, 1'b0);
    n_checks++;
    if (frame_cnt_v[0] !== 8'(exp_cnt[0])) begin
      n_fail++;
      $display("FAIL early_ready: cnt=%0d required %0d", frame_cnt_v[0], exp_cnt[0]);
    end
    get_result(0, 0);
    set_dv(8, 8, 2, 7, 1);
    send_frame(0, 3'b001, 5, 0, 1'b0);
    get_result(0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    stub_neg1 = 1'b1;
    for (int f = 0; f < 257; f++) begin
      for (int k = 0; k < 5; k++) dv[k] = 4'($urandom_range(0, 15));
      send_frame(0, 3'($urandom_range(0, 7)), 5, 0, 1'b0);
      get_result(0, 0);
    end
    n_checks++;
    if (frame_cnt_v[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap: cnt=%0d required 1", frame_cnt_v[0]);
    end
    stub_neg1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stub_neg1 = 1'b0;
    in_data = '0;
    in_opt = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0;
      out_ready_v[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_opcode();
    test_throttle();
    test_latency();
    test_reset_midop();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_frame_loader.md
Name: cc_frame_loader

Overview:
- Serial front-end and result collector for the combinational code calculator.
- Accepts one 4-bit operand per beat over a valid/ready stream, assembles a 5-operand frame plus a 3-bit opcode, and drives them as registered values into the calculator.
- Waits a programmable settle time, captures the signed 10-bit result, and returns it on a valid/ready result stream.
- This block is the initiator side of the calculator's operand/result interface.

Parameters:
- CALC_LAT, 1: settle cycles between operand update and result capture; legal range 0..15.
- CNT_W, 8: width of the completed-frame counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  4  unsigned operand nibble.
- in_opt  in  3  opcode; sampled only on the first beat of a frame.
- cc_opt  out  3  registered opcode to calculator.
- cc_in0..cc_in4  out  4 each  registered operands to calculator; beat k drives cc_in(k).
- cc_out  in  10  signed result from calculator.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  10  signed captured result.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  CNT_W  count of delivered results.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock, single clock domain.
  - On any rising edge with rst=1: state=IDLE, beat count=0, wait count=0.
  - cc_opt=0, cc_in0..4=0, out_data=0, out_valid=0, frame_cnt=0, busy=0.
  - Reset mid-frame or mid-hold discards the partial frame or pending result without signalling.
- States: IDLE, LOAD, CALC, HOLD.
- in_ready is combinational: 1 in IDLE and LOAD, 0 in CALC and HOLD. A beat is accepted on an edge where in_valid and in_ready are both 1.
- IDLE:
  - On an accepted beat: cc_in0 <= in_data, cc_opt <= in_opt, beat count <= 1, go to LOAD.
- LOAD:
  - On an accepted beat: cc_in(beat count) <= in_data; in_opt is ignored.
  - On the beat writing cc_in4: wait count <= CALC_LAT, go to CALC.
  - in_valid=0 stalls indefinitely with no timeout; all registers hold.
- CALC:
  - If wait count == 0: out_data <= cc_out, out_valid <= 1, go to HOLD. Otherwise decrement the wait count.
  - out_valid rises exactly CALC_LAT+1 cycles after the edge that accepted the fifth beat.
- HOLD:
  - out_valid=1; out_data, cc_in0..4 and cc_opt are stable.
  - When out_valid and out_ready are both 1 on an edge: out_valid <= 0, frame_cnt <= frame_cnt+1 (wraps modulo 2^CNT_W), go to IDLE.
  - A new frame's first beat is accepted no earlier than the cycle after the result handshake.
- out_ready asserted outside HOLD has no effect.
- cc_in0..4 and cc_opt keep their last values after a frame until overwritten by the next frame. Operands from an earlier frame stay visible in slots not yet rewritten.
- out_data is a registered copy of cc_out. No arithmetic, sign extension or saturation is applied.
- busy = (state != IDLE).

Test Plan:
- Basic, opt=000: calculator attached, CALC_LAT=1; send opt=000 and beats 1,2,3,4,5 back-to-back.
  - in_ready high for 5 cycles; cc_in0..4=1..5.
  - out_valid rises 2 cycles after the fifth beat; out_data=6; frame_cnt=1 after handshake.
- Opcode path, opt=100: same beats with opt=100 on beat 0 and in_opt toggled to 011 on beats 1-4.
  - cc_opt stays 100; out_data=7.
- Throttling: in_valid gaps of 3 idle cycles between beats, and out_ready held low 10 cycles in HOLD.
  - No beat lost or duplicated; out_valid and out_data stable for the full hold; in_ready=0 throughout.
- Latency parameter: CALC_LAT=0 and CALC_LAT=15.
  - out_valid rises exactly 1 and 16 cycles after the fifth-beat edge, respectively.
- Reset mid-operation: assert rst after beat 3, then again while in HOLD.
  - Next cycle: all outputs 0, state IDLE, frame_cnt unchanged at 0.
  - A following full frame completes normally.
- Counter wrap: CNT_W=8, run 257 frames with the calculator stubbed to cc_out=-1.
  - out_data=10'h3FF every frame; frame_cnt reads 255 then 0 then 1.
